// File: rtl/touch_key_pkg.sv
// touch_key_pkg: LED mode codes and the per-channel press FSM state encoding
package touch_key_pkg;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_MOMENT = 2'b01;
    localparam logic [1:0] MODE_LONG   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_e;

endpackage

// File: rtl/touch_key_ctrl_if.sv
// touch_key_ctrl_if: touch pad / LED bundle between board-side logic and the controller
//   touch       raw pad levels, 1 = touched
//   mode        per-channel LED mode, bits [2i+1:2i] for channel i
//   led         LED drive, 1 = on
//   press_pulse one-cycle pulse per accepted press
//   long_pulse  one-cycle pulse per accepted long press
//   key_level   debounced key level
interface touch_key_ctrl_if #(parameter int CH = 4);

    logic [CH-1:0]   touch;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   led;
    logic [CH-1:0]   press_pulse;
    logic [CH-1:0]   long_pulse;
    logic [CH-1:0]   key_level;

    modport master (output touch, mode, input led, press_pulse, long_pulse, key_level);
    modport slave  (input touch, mode, output led, press_pulse, long_pulse, key_level);

endinterface

// File: rtl/touch_key_chan.sv
// touch_key_chan: one touch channel - synchroniser, debouncer, press/long-press FSM, LED
//   clk_i, rst_i  clock and synchronous active-high reset
//   touch_i       raw asynchronous pad level
//   mode_i        LED mode (toggle / momentary / long toggle / hold)
//   led_o         LED drive
//   press_o       one-cycle pulse on accepted press
//   long_o        one-cycle pulse on accepted long press
//   level_o       debounced key level
module touch_key_chan
    import touch_key_pkg::*;
#(
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       touch_i,
    input  logic [1:0] mode_i,
    output logic       led_o,
    output logic       press_o,
    output logic       long_o,
    output logic       level_o
);

    localparam int CW = $clog2(LONG_CNT + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] deb_q;
    logic [CW-1:0] hold_q;
    logic          level_q;
    logic          led_q;
    logic          press_q;
    logic          long_q;
    key_state_e    state_q;

    logic          differ;
    logic          accept;
    logic          level_d;
    logic [CW-1:0] hold_inc;
    logic          press_d;
    logic          long_d;
    logic          led_d;

    // Events are derived from the next debounced level so that the pulses,
    // key_level and the LED all change on the same edge.
    assign differ   = sync_q[1] != level_q;
    assign accept   = differ && (deb_q == CW'(DEB_CNT));
    assign level_d  = accept ? sync_q[1] : level_q;
    assign hold_inc = hold_q + 1'b1;
    assign press_d  = (state_q == IDLE) && level_d;
    assign long_d   = (state_q == PRESSED) && level_d && (hold_inc == CW'(LONG_CNT));
    assign led_d    = (mode_i == MODE_TOGGLE) ? led_q ^ press_d :
                      (mode_i == MODE_MOMENT) ? level_d :
                      (mode_i == MODE_LONG)   ? led_q ^ long_d : led_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            deb_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            led_q   <= 1'b0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= {sync_q[0], touch_i};
            deb_q   <= (differ && !accept) ? deb_q + 1'b1 : '0;
            level_q <= level_d;
            led_q   <= led_d;
            press_q <= press_d;
            long_q  <= long_d;
            case (state_q)
                IDLE: begin
                    if (press_d) begin
                        state_q <= PRESSED;
                        hold_q  <= '0;
                    end
                end
                PRESSED: begin
                    if (!level_d) state_q <= IDLE;
                    else if (long_d) begin
                        state_q <= LONG;
                        hold_q  <= hold_inc;
                    end else hold_q <= hold_inc;
                end
                // hold_q stays at LONG_CNT here, so no further long pulse can fire
                LONG: if (!level_d) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led_o   = led_q;
    assign press_o = press_q;
    assign long_o  = long_q;
    assign level_o = level_q;

endmodule

// File: rtl/touch_key_ctrl.sv
// touch_key_ctrl: CH independent touch-key channels driving one LED each
//   sys_clk  system clock
//   sys_rst  synchronous active-high reset
//   bus      slave side of touch_key_ctrl_if (touch/mode in; led, pulses, key_level out)
module touch_key_ctrl #(
    parameter int CH       = 4,
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input logic              sys_clk,
    input logic              sys_rst,
    touch_key_ctrl_if.slave  bus
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        touch_key_chan #(
            .DEB_CNT  (DEB_CNT),
            .LONG_CNT (LONG_CNT)
        ) u_chan (
            .clk_i   (sys_clk),
            .rst_i   (sys_rst),
            .touch_i (bus.touch[i]),
            .mode_i  (bus.mode[2*i +: 2]),
            .led_o   (bus.led[i]),
            .press_o (bus.press_pulse[i]),
            .long_o  (bus.long_pulse[i]),
            .level_o (bus.key_level[i])
        );
    end

endmodule

// File: tb/tb_touch_key_ctrl.sv
// tb_touch_key_ctrl: directed scenarios plus randomized run against a timing-rule reference model
module tb_touch_key_ctrl;

    localparam int CH   = 4;
    localparam int DEB  = 8;
    localparam int LNG  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    touch_key_ctrl_if #(.CH(CH)) bus ();

    touch_key_ctrl #(.CH(CH), .DEB_CNT(DEB), .LONG_CNT(LNG)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        bus.touch = '0;
        bus.mode  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.led !== 4'h0) $display("FAIL reset_led got %b exp 0000", bus.led); else pass_cnt++;
        total_cnt++; if (bus.press_pulse !== 4'h0) $display("FAIL reset_press got %b exp 0000", bus.press_pulse); else pass_cnt++;
        total_cnt++; if (bus.long_pulse !== 4'h0) $display("FAIL reset_long got %b exp 0000", bus.long_pulse); else pass_cnt++;
        total_cnt++; if (bus.key_level !== 4'h0) $display("FAIL reset_level got %b exp 0000", bus.key_level); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        bus.mode = '0;
        bus.touch[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 19) bus.touch[0] = 1'b0;
            total_cnt++; if (bus.press_pulse[0] !== (c == 10)) $display("FAIL clean_press c=%0d got %b exp %b", c, bus.press_pulse[0], c == 10); else pass_cnt++;
            total_cnt++; if (bus.led[0] !== (c >= 10)) $display("FAIL clean_led c=%0d got %b exp %b", c, bus.led[0], c >= 10); else pass_cnt++;
            total_cnt++; if (bus.key_level[0] !== (c >= 10 && c < 30)) $display("FAIL clean_level c=%0d got %b exp %b", c, bus.key_level[0], c >= 10 && c < 30); else pass_cnt++;
        end
        bus.touch[0] = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (c == 11) bus.touch[0] = 1'b0;
            total_cnt++; if (bus.press_pulse[0] !== (c == 10)) $display("FAIL second_press c=%0d got %b exp %b", c, bus.press_pulse[0], c == 10); else pass_cnt++;
            total_cnt++; if (bus.led[0] !== (c < 10)) $display("FAIL second_led c=%0d got %b exp %b", c, bus.led[0], c < 10); else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int np = 0;
        int nl = 0;
        bus.touch[1] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c == 6) bus.touch[1] = 1'b0;
            total_cnt++; if (bus.press_pulse[1] !== 1'b0) $display("FAIL glitch_press c=%0d got %b exp 0", c, bus.press_pulse[1]); else pass_cnt++;
            total_cnt++; if (bus.key_level[1] !== 1'b0) $display("FAIL glitch_level c=%0d got %b exp 0", c, bus.key_level[1]); else pass_cnt++;
        end
        bus.touch[1] = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 14) bus.touch[1] = 1'b0;
            if (c == 17) bus.touch[1] = 1'b1;
            if (c == 39) bus.touch[1] = 1'b0;
            if (bus.press_pulse[1]) np++;
            if (bus.long_pulse[1]) nl++;
        end
        total_cnt++; if (np != 1) $display("FAIL dropout_press_count got %0d exp 1", np); else pass_cnt++;
        total_cnt++; if (nl != 1) $display("FAIL dropout_long_count got %0d exp 1", nl); else pass_cnt++;
    endtask

    task automatic test_long_toggle();
        bus.mode[5:4] = 2'b10;
        bus.touch[2] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 59) bus.touch[2] = 1'b0;
            total_cnt++; if (bus.press_pulse[2] !== (c == 10)) $display("FAIL long_mode_press c=%0d got %b exp %b", c, bus.press_pulse[2], c == 10); else pass_cnt++;
            total_cnt++; if (bus.long_pulse[2] !== (c == 42)) $display("FAIL long_mode_pulse c=%0d got %b exp %b", c, bus.long_pulse[2], c == 42); else pass_cnt++;
            total_cnt++; if (bus.led[2] !== (c >= 42)) $display("FAIL long_mode_led c=%0d got %b exp %b", c, bus.led[2], c >= 42); else pass_cnt++;
        end
    endtask

    task automatic test_momentary();
        bus.mode[7:6] = 2'b01;
        bus.touch[3] = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (c == 14) bus.touch[3] = 1'b0;
            total_cnt++; if (bus.led[3] !== (c >= 10 && c < 25)) $display("FAIL moment_led c=%0d got %b exp %b", c, bus.led[3], c >= 10 && c < 25); else pass_cnt++;
        end
        bus.mode[7:6] = 2'b00;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.led[3] !== 1'b0) $display("FAIL moment_exit_led got %b exp 0", bus.led[3]); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mode  = 8'b11_10_01_00;
        bus.touch = 4'hF;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (c == 11) bus.touch = 4'h0;
            if (c == 9) begin
                total_cnt++; if (bus.press_pulse !== 4'h0) $display("FAIL simul_early got %b exp 0000", bus.press_pulse); else pass_cnt++;
            end
            if (c == 10) begin
                total_cnt++; if (bus.press_pulse !== 4'hF) $display("FAIL simul_press got %b exp 1111", bus.press_pulse); else pass_cnt++;
                total_cnt++; if (bus.led !== 4'b0011) $display("FAIL simul_led got %b exp 0011", bus.led); else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mode  = '0;
        bus.touch = 4'b0001;
        repeat (15) @(negedge clk);
        total_cnt++; if (bus.led[0] !== 1'b1) $display("FAIL midrst_pre_led got %b exp 1", bus.led[0]); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (bus.led !== 4'h0) $display("FAIL midrst_led got %b exp 0000", bus.led); else pass_cnt++;
        total_cnt++; if (bus.key_level !== 4'h0) $display("FAIL midrst_level got %b exp 0000", bus.key_level); else pass_cnt++;
        total_cnt++; if ((bus.press_pulse | bus.long_pulse) !== 4'h0) $display("FAIL midrst_pulses got %b exp 0000", bus.press_pulse | bus.long_pulse); else pass_cnt++;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            total_cnt++; if (bus.press_pulse[0] !== (c == 10)) $display("FAIL midrst_repress c=%0d got %b exp %b", c, bus.press_pulse[0], c == 10); else pass_cnt++;
            total_cnt++; if (bus.key_level[0] !== (c >= 10)) $display("FAIL midrst_level_re c=%0d got %b exp %b", c, bus.key_level[0], c >= 10); else pass_cnt++;
        end
        bus.touch = '0;
        repeat (15) @(negedge clk);
    endtask

    // Reference model: a key level flips once the last DEB+1 synchronised samples
    // (touch from 2..DEB+2 edges ago) all disagree with it; a long press fires
    // LNG edges after its press if the key is still down; LEDs follow the mode rules.
    task automatic test_random();
        bit [DEB+2:0] hist [CH];
        bit [DEB:0]   win;
        logic [CH-1:0] lvl, led, prs, lng, done, cur;
        int hc [CH];
        int dur [CH];
        bit rst_v;
        bit prev;
        for (int i = 0; i < CH; i++) begin
            hist[i] = '0;
            hc[i] = 0;
            dur[i] = 0;
        end
        lvl = '0; led = '0; prs = '0; lng = '0; done = '0; cur = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_v = (cyc == 0) || ($urandom_range(0, 599) == 0);
            for (int i = 0; i < CH; i++) begin
                if (dur[i] == 0) begin
                    cur[i] = ~cur[i];
                    dur[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : $urandom_range(9, 50);
                end
                dur[i]--;
            end
            if ($urandom_range(0, 99) == 0) bus.mode = 8'($urandom);
            bus.touch = cur;
            rst = rst_v;
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (rst_v) begin
                    hist[i] = '0;
                    lvl[i] = 0; led[i] = 0; prs[i] = 0; lng[i] = 0; done[i] = 0; hc[i] = 0;
                end else begin
                    hist[i] = {hist[i][DEB+1:0], cur[i]};
                    win = hist[i][DEB+2:2];
                    prev = lvl[i];
                    if (lvl[i] ? (win == '0) : (&win)) lvl[i] = ~lvl[i];
                    prs[i] = lvl[i] & ~prev;
                    lng[i] = 1'b0;
                    if (prs[i]) begin
                        hc[i] = 0;
                        done[i] = 1'b0;
                    end else if (lvl[i] && !done[i]) begin
                        hc[i]++;
                        if (hc[i] == LNG) begin
                            lng[i] = 1'b1;
                            done[i] = 1'b1;
                        end
                    end
                    case (bus.mode[2*i +: 2])
                        2'b00: led[i] = led[i] ^ prs[i];
                        2'b01: led[i] = lvl[i];
                        2'b10: led[i] = led[i] ^ lng[i];
                        default: led[i] = led[i];
                    endcase
                end
            end
            total_cnt++; if (bus.key_level !== lvl) $display("FAIL rand_level cyc=%0d got %b exp %b", cyc, bus.key_level, lvl); else pass_cnt++;
            total_cnt++; if (bus.press_pulse !== prs) $display("FAIL rand_press cyc=%0d got %b exp %b", cyc, bus.press_pulse, prs); else pass_cnt++;
            total_cnt++; if (bus.long_pulse !== lng) $display("FAIL rand_long cyc=%0d got %b exp %b", cyc, bus.long_pulse, lng); else pass_cnt++;
            total_cnt++; if (bus.led !== led) $display("FAIL rand_led cyc=%0d got %b exp %b", cyc, bus.led, led); else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_toggle();
        test_momentary();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
